ahb_slave_ctrl: RTL and testbench
=================================

Name: ahb_slave_ctrl

Overview:
- AHB responder (slave) control block: the far end of the AHB master interface driven by the AXI-to-AHB bridge.
- Samples AHB address phases and converts each accepted beat into one request on a simple memory-side handshake (mem_req/mem_ack).
- Drives HREADY, HRESP and HRDATA back to the master.
- Sits between the AHB fabric and an SRAM or register-file backend.

Parameters:
- ADDR_BITS, 24, width of HADDR and mem_addr.
- DATA_BITS, 32, width of HWDATA, HRDATA, mem_wdata and mem_rdata (32 or 64).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  ADDR_BITS  transfer address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HBURST  in  3  burst type; informational only
- HSIZE  in  2  bytes per beat = 1<<HSIZE
- HWRITE  in  1  1 = write
- HWDATA  in  DATA_BITS  write data, valid during the data phase
- HRDATA  out  DATA_BITS  read data
- HREADY  out  1  transfer-done / wait indication
- HRESP  out  2  OKAY=00, ERROR=01
- mem_req  out  1  memory request, held high until acked
- mem_write  out  1  request is a write
- mem_addr  out  ADDR_BITS  latched beat address
- mem_size  out  2  latched HSIZE
- mem_wdata  out  DATA_BITS  equals HWDATA while mem_req & mem_write
- mem_rdata  in  DATA_BITS  read data, valid with mem_ack
- mem_ack  in  1  completes the outstanding request

Behaviour:
- Single clock domain, synchronous active-high reset.
- Reset values: HREADY=1, HRESP=00, HRDATA=0, mem_req=0, mem_write=0, mem_addr=0, mem_size=0. FSM resets to IDLE.
- Reset asserted mid-transfer: mem_req deasserts on the next edge and the outstanding beat is abandoned.
- Accept condition (address phase): HREADY & HSEL & HTRANS[1]. On accept, latch HADDR, HSIZE and HWRITE into mem_addr, mem_size and mem_write.
- IDLE or BUSY transfers, or HSEL=0, while HREADY=1: zero-wait OKAY response, no mem_req, FSM stays in the current accepting state.
- FSM states:
  - IDLE: HREADY=1, HRESP=00. On accept -> ACCESS.
  - ACCESS: HREADY=0, mem_req=1. mem_wdata driven from HWDATA, which stays stable because HREADY=0. On mem_ack: for a read, register mem_rdata into HRDATA; -> DONE. With no mem_ack, stay in ACCESS indefinitely; there is no timeout.
  - DONE: HREADY=1, HRESP=00, mem_req=0. HRDATA holds its value. This cycle is also an address phase: on accept -> ACCESS, else -> IDLE.
  - ERR1: HREADY=0, HRESP=01. -> ERR2.
  - ERR2: HREADY=1, HRESP=01. Accept is evaluated here as in DONE: -> ACCESS or IDLE.
- Latency: minimum data phase is 2 cycles (ACCESS with same-cycle mem_ack, then DONE).
- Data phase length = 1 + cycles from mem_req rise to mem_ack + 1.
- Back-to-back bursts: each SEQ beat is accepted in the DONE cycle of the previous beat, with no idle gap. Each beat uses the HADDR presented by the master; no internal address increment.
- mem_ack while mem_req=0 is ignored.
- HRDATA changes only on a read mem_ack; write beats leave it unchanged.

Optional Feature:
- Macro: AHB_SLAVE_ERR_EN.
- Defined: at accept, flag an error if the address is misaligned (HADDR & ((1<<HSIZE)-1) != 0) or the size is too large ((1<<HSIZE)*8 > DATA_BITS).
  - Flagged beat -> ERR1 instead of ACCESS.
  - No mem_req is issued; mem_addr and mem_size are not updated.
  - Gives the AHB two-cycle ERROR response.
- Undefined: no checks. mem_addr = HADDR with the low log2(1<<HSIZE) bits forced to 0. Oversized HSIZE is passed through unchanged. ERR1 and ERR2 are not built, and HRESP is constant 00.

Test Plan:
- Single read: NONSEQ HADDR=0x000010, HSIZE=10, mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> HREADY low 4 cycles; HRDATA=0xDEADBEEF in the DONE cycle; HRESP=00.
- Single write: HADDR=0x000020, HWDATA=0x12345678, mem_ack same cycle as mem_req -> mem_write=1, mem_wdata=0x12345678, exactly one mem_req cycle, HREADY low 1 cycle.
- INCR4 read at 0x100, mem_ack always 1 -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C; 4 mem_req pulses; HREADY pattern 0,1,0,1,0,1,0,1; no gap between beats.
- BUSY inserted between SEQ beats, and IDLE with HSEL=0 -> no mem_req, HREADY stays 1, HRESP=00.
- AHB_SLAVE_ERR_EN defined: HADDR=0x000102, HSIZE=10 -> HRESP=01 for 2 cycles with HREADY=0 then 1; no mem_req. Macro undefined: same stimulus -> mem_addr=0x000100 and a normal OKAY response.
- Reset asserted in ACCESS with mem_ack held low -> next cycle mem_req=0, HREADY=1, HRESP=00, HRDATA=0. A subsequent NONSEQ is accepted normally.

Source files
------------

// File: rtl/ahb_slave_ctrl.sv
// AHB responder control: accepts AHB address phases, turns each accepted beat
// into one mem_req/mem_ack handshake toward an SRAM or register-file backend,
// and drives HREADY/HRESP/HRDATA back to the master.
// Optional build macro: AHB_SLAVE_ERR_EN. When defined, misaligned or oversized
// beats get a two-cycle ERROR response and never reach the memory side.
// When undefined, beat addresses are aligned down to the transfer size and
// HRESP is always OKAY.
module ahb_slave_ctrl #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic [ADDR_BITS-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HSIZE,
  input  logic                 HWRITE,
  input  logic [DATA_BITS-1:0] HWDATA,
  output logic [DATA_BITS-1:0] HRDATA,
  output logic                 HREADY,
  output logic [1:0]           HRESP,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [1:0]           mem_size,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ack
);

`ifdef AHB_SLAVE_ERR_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
`endif

  state_t               state_q, state_d;
  logic                 accept_s;
  logic                 err_s;
  logic                 go_s;
  logic [ADDR_BITS-1:0] beat_addr_s;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 mem_write_q, mem_write_d;
  logic [DATA_BITS-1:0] hrdata_q, hrdata_d;

  // HBURST carries no information this block needs; beats use HADDR as given.
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  // Low-address bits that must be zero for a beat of the given size.
  function automatic logic [ADDR_BITS-1:0] size_mask(input logic [1:0] size);
    logic [ADDR_BITS-1:0] m;
    case (size)
      2'd0:    m = {ADDR_BITS{1'b0}};
      2'd1:    m = ADDR_BITS'(3'd1);
      2'd2:    m = ADDR_BITS'(3'd3);
      default: m = ADDR_BITS'(3'd7);
    endcase
    return m;
  endfunction

  // An address phase is only sampled while the previous data phase completes.
  assign accept_s = HREADY & HSEL & HTRANS[1];

`ifdef AHB_SLAVE_ERR_EN
  assign err_s       = (|(HADDR & size_mask(HSIZE))) |
                       ((32'd8 << HSIZE) > 32'(DATA_BITS));
  assign beat_addr_s = HADDR;
`else
  assign err_s       = 1'b0;
  assign beat_addr_s = HADDR & ~size_mask(HSIZE);
`endif

  assign go_s = accept_s & ~err_s;

  // State register; reset abandons any outstanding beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ACCESS waits on mem_ack, every HREADY=1 state is an address phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCESS: begin
        if (mem_ack) state_d = ST_DONE;
        else         state_d = ST_ACCESS;
      end
`ifdef AHB_SLAVE_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        if (go_s)          state_d = ST_ACCESS;
`ifdef AHB_SLAVE_ERR_EN
        else if (accept_s) state_d = ST_ERR1;
`endif
        else               state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    HREADY  = 1'b1;
    HRESP   = 2'b00;
    mem_req = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        HREADY  = 1'b0;
        mem_req = 1'b1;
      end
`ifdef AHB_SLAVE_ERR_EN
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 2'b01;
      end
      ST_ERR2: begin
        HRESP = 2'b01;
      end
`endif
      default: begin
        HREADY  = 1'b1;
        HRESP   = 2'b00;
        mem_req = 1'b0;
      end
    endcase
  end

  // Beat attributes latch on a good accept; HRDATA only moves on a read ack.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_write_d = mem_write_q;
    hrdata_d    = hrdata_q;
    if (go_s) begin
      mem_addr_d  = beat_addr_s;
      mem_size_d  = HSIZE;
      mem_write_d = HWRITE;
    end else begin
      mem_addr_d  = mem_addr_q;
    end
    if (mem_req & mem_ack & ~mem_write_q) begin
      hrdata_d = mem_rdata;
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= {ADDR_BITS{1'b0}};
      mem_size_q  <= 2'b00;
      mem_write_q <= 1'b0;
      hrdata_q    <= {DATA_BITS{1'b0}};
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_write_q <= mem_write_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // HWDATA is held by the master while HREADY=0, so it can feed memory directly.
  assign mem_wdata = (mem_req & mem_write_q) ? HWDATA : {DATA_BITS{1'b0}};
  assign mem_addr  = mem_addr_q;
  assign mem_size  = mem_size_q;
  assign mem_write = mem_write_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Scoreboard bench for ahb_slave_ctrl: a pipelined AHB master driver pushes
// expectations from a behavioural memory model, a randomized-latency memory
// responder answers mem_req, and a monitor pops and compares.
module tb_ahb_slave_ctrl;
  localparam int AB = 24;
  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          HSEL;
  logic [AB-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic [1:0]    HSIZE;
  logic          HWRITE;
  logic [DB-1:0] HWDATA;
  logic [DB-1:0] HRDATA;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic          mem_req;
  logic          mem_write;
  logic [AB-1:0] mem_addr;
  logic [1:0]    mem_size;
  logic [DB-1:0] mem_wdata;
  logic [DB-1:0] mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  ahb_slave_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // kind: 0 = IDLE, 1 = BUSY, 2 = NONSEQ with HSEL=0, 3 = real transfer
  typedef struct {
    int          kind;
    logic [1:0]  trans;
    logic [23:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } memx_t;

  stim_t       stim_q[$];
  memx_t       mem_q[$];
  logic [31:0] resp_q[$];
  int          lat_q[$];
  int          err_q[$];
  logic [31:0] model_mem[int];
  logic [31:0] bench_mem[int];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  bit          hold_ack = 1'b0;
  int          fixed_dly = -1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] dflt(logic [23:0] a);
    return {8'hA5, a};
  endfunction

  function automatic logic [23:0] align(logic [23:0] a, logic [1:0] s);
    return (a >> s) << s;
  endfunction

  function automatic bit is_err(logic [23:0] a, logic [1:0] s);
`ifdef AHB_SLAVE_ERR_EN
    int ai = int'(a);
    int sz = 1 << s;
    return ((ai % sz) != 0) || ((8 * sz) > DB);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: what each issued beat must look like at the memory side
  // and what HRDATA must read when it completes.
  function automatic void model_issue(stim_t it);
    memx_t       m;
    logic [31:0] e;
    if (is_err(it.addr, it.size)) begin
      err_q.push_back(1);
    end else begin
      m.addr  = align(it.addr, it.size);
      m.wr    = it.wr;
      m.size  = it.size;
      m.wdata = it.wdata;
      mem_q.push_back(m);
      if (it.wr) begin
        model_mem[int'(m.addr)] = it.wdata;
        resp_q.push_back(last_rd);
      end else begin
        e = model_mem.exists(int'(m.addr)) ? model_mem[int'(m.addr)] : dflt(m.addr);
        last_rd = e;
        resp_q.push_back(e);
      end
    end
  endfunction

  function automatic stim_t mk(int kind, logic [1:0] trans, logic [23:0] addr,
                               logic [1:0] size, logic wr, logic [31:0] wdata);
    stim_t s;
    s.kind = kind; s.trans = trans; s.addr = addr;
    s.size = size; s.wr = wr; s.wdata = wdata;
    return s;
  endfunction

  function automatic stim_t mk_rand();
    int r = int'($urandom_range(0, 99));
    int k = (r < 60) ? 3 : (r < 75) ? 0 : (r < 85) ? 1 : 2;
    return mk(k, ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11,
              24'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
  endfunction

  // AHB master: new address phase whenever HREADY is high, write data one cycle later.
  initial begin
    stim_t       it;
    bit          wd_pending = 1'b0;
    logic [31:0] wd_val = 32'd0;
    HSEL = 1'b0; HADDR = 24'd0; HTRANS = 2'b00; HBURST = 3'b000;
    HSIZE = 2'b10; HWRITE = 1'b0; HWDATA = 32'd0;
    forever begin
      @(negedge clk);
      if (wd_pending) begin
        HWDATA = wd_val;
        wd_pending = 1'b0;
      end
      if (reset) begin
        HSEL = 1'b0; HTRANS = 2'b00; wd_pending = 1'b0;
      end else if (HREADY === 1'b1) begin
        if (stim_q.size() > 0) it = stim_q.pop_front();
        else it = mk(0, 2'b00, 24'd0, 2'b10, 1'b0, 32'd0);
        HSEL   = (it.kind != 2);
        HTRANS = (it.kind == 0) ? 2'b00 : (it.kind == 1) ? 2'b01 :
                 (it.kind == 2) ? 2'b10 : it.trans;
        HBURST = (it.trans == 2'b11) ? 3'b011 : 3'b000;
        HADDR  = it.addr;
        HSIZE  = it.size;
        HWRITE = it.wr;
        if (it.kind == 3) begin
          model_issue(it);
          if (it.wr) begin
            wd_pending = 1'b1;
            wd_val = it.wdata;
          end
        end
      end
    end
  end

  // Memory responder: picks a latency per request, ignores-able noise on mem_ack otherwise.
  initial begin
    int cnt = 0;
    bit active = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!mem_req || reset) begin
        active = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
          lat_q.push_back(cnt + 1);
        end
        if (hold_ack) begin
          mem_ack = 1'b0;
        end else if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = bench_mem.exists(int'(mem_addr)) ? bench_mem[int'(mem_addr)] : dflt(mem_addr);
        end else begin
          mem_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Monitor: compares memory handshakes, completions and error responses.
  initial begin
    memx_t       m;
    bit          done_next = 1'b0;
    bit          err_next = 1'b0;
    int          low_cnt = 0;
    int          el;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        done_next = 1'b0; err_next = 1'b0; low_cnt = 0;
      end else begin
        if (done_next) begin
          done_next = 1'b0;
          check("done_hready", 64'(HREADY), 64'd1);
          if (resp_q.size() == 0) check("resp_underflow", 64'd1, 64'd0);
          else check("hrdata", 64'(HRDATA), 64'(resp_q.pop_front()));
          if (lat_q.size() == 0) check("lat_underflow", 64'd1, 64'd0);
          else check("wait_cycles", 64'(low_cnt), 64'(lat_q.pop_front()));
        end
        if (err_next) begin
          err_next = 1'b0;
          check("err2_resp", 64'({HREADY, HRESP}), 64'(3'b101));
        end else if (HRESP != 2'b00 && err_q.size() > 0) begin
          el = err_q.pop_front();
          check("err1_resp", 64'({HREADY, HRESP}), 64'(3'b001));
          err_next = (el != 0);
        end else begin
          check("hresp_okay", 64'(HRESP), 64'd0);
        end
        if (mem_req && mem_ack) begin
          if (mem_q.size() == 0) begin
            check("unexpected_mem_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            m = mem_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(m.addr));
            check("mem_write", 64'(mem_write), 64'(m.wr));
            check("mem_size", 64'(mem_size), 64'(m.size));
            if (m.wr) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
          end
          if (mem_write) bench_mem[int'(mem_addr)] = mem_wdata;
          done_next = 1'b1;
        end
        if (HREADY) low_cnt = 0;
        else low_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain();
    int left = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #4;
      left = stim_q.size() + mem_q.size() + resp_q.size() + lat_q.size() + err_q.size();
      if (left == 0) break;
    end
    check("drain_pending", 64'(left), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    last_rd = 32'd0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_hready", 64'(HREADY), 64'd1);
    check("rst_hresp", 64'(HRESP), 64'd0);
    check("rst_hrdata", 64'(HRDATA), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_size", 64'(mem_size), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Single read with three-cycle memory latency.
    bench_mem[16] = 32'hDEADBEEF;
    model_mem[16] = 32'hDEADBEEF;
    fixed_dly = 3;
    stim_q.push_back(mk(3, 2'b10, 24'h000010, 2'b10, 1'b0, 32'd0));
    wait_drain();
    check("single_read_hrdata", 64'(HRDATA), 64'hDEADBEEF);

    // Single zero-wait write; HRDATA must not move.
    fixed_dly = 0;
    stim_q.push_back(mk(3, 2'b10, 24'h000020, 2'b10, 1'b1, 32'h12345678));
    wait_drain();
    check("write_keeps_hrdata", 64'(HRDATA), 64'hDEADBEEF);

    // INCR4 read burst, then the same burst with BUSY / unselected / IDLE gaps.
    stim_q.push_back(mk(3, 2'b10, 24'h000100, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b11, 24'h000104, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b11, 24'h000108, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b11, 24'h00010C, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b10, 24'h000100, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(1, 2'b01, 24'h000104, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b11, 24'h000104, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(2, 2'b10, 24'h000108, 2'b10, 1'b1, 32'd0));
    stim_q.push_back(mk(0, 2'b00, 24'h000108, 2'b10, 1'b0, 32'd0));
    stim_q.push_back(mk(3, 2'b11, 24'h000108, 2'b10, 1'b0, 32'd0));
    wait_drain();

    // Misaligned word access: aligned-down OKAY beat, or ERROR with the check built.
    fixed_dly = 1;
    stim_q.push_back(mk(3, 2'b10, 24'h000102, 2'b10, 1'b0, 32'd0));
    wait_drain();

    // Random traffic with random memory latency.
    fixed_dly = -1;
    for (int i = 0; i < 300; i++) stim_q.push_back(mk_rand());
    wait_drain();

    // Reset while a beat is stuck in its access phase.
    hold_ack = 1'b1;
    stim_q.push_back(mk(3, 2'b10, 24'h000040, 2'b10, 1'b0, 32'd0));
    repeat (4) @(negedge clk);
    #2;
    check("stuck_in_access", 64'({mem_req, HREADY}), 64'(2'b10));
    reset = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
    stim_q.delete(); mem_q.delete(); resp_q.delete(); lat_q.delete(); err_q.delete();
    last_rd = 32'd0;
    hold_ack = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_hready", 64'(HREADY), 64'd1);
    check("midrst_hresp", 64'(HRESP), 64'd0);
    check("midrst_hrdata", 64'(HRDATA), 64'd0);

    // Traffic after reset is accepted normally.
    stim_q.push_back(mk(3, 2'b10, 24'h000010, 2'b10, 1'b0, 32'd0));
    for (int i = 0; i < 60; i++) stim_q.push_back(mk_rand());
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
